// File: rtl/l2_msg_pkg.sv
// Shared message-type codes, scheduler state enum and cur_msg_state encodings
// for the L2 message scheduler.
package l2_msg_pkg;

    // Request set (msg1)
    localparam logic [7:0] L2_MSG_GET_S    = 8'h01;
    localparam logic [7:0] L2_MSG_GET_M    = 8'h02;
    localparam logic [7:0] L2_MSG_UPGRADE  = 8'h03;
    // Writeback / ack set (msg3)
    localparam logic [7:0] L2_MSG_PUT_M    = 8'h11;
    localparam logic [7:0] L2_MSG_INV_ACK  = 8'h12;
    localparam logic [7:0] L2_MSG_PUT_S    = 8'h13;
    // Response set (msg2)
    localparam logic [7:0] L2_MSG_DATA_S   = 8'h21;
    localparam logic [7:0] L2_MSG_DATA_E   = 8'h22;
    localparam logic [7:0] L2_MSG_DATA_M   = 8'h23;
    localparam logic [7:0] L2_MSG_PUT_ACK  = 8'h24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_EXEC  = 3'd2,
        ST_ACK   = 3'd3,
        ST_RESP  = 3'd4
    } sched_state_e;

    localparam logic [1:0] CUR_IDLE = 2'd0;
    localparam logic [1:0] CUR_EXEC = 2'd1;
    localparam logic [1:0] CUR_ACK  = 2'd2;
    localparam logic [1:0] CUR_RESP = 2'd3;

    localparam logic [1:0] FAIR_MAX = 2'd3;

    function automatic logic [1:0] cur_state_enc(input sched_state_e s);
        logic [1:0] enc;
        case (s)
            ST_ISSUE, ST_EXEC: enc = CUR_EXEC;
            ST_ACK:            enc = CUR_ACK;
            ST_RESP:           enc = CUR_RESP;
            default:           enc = CUR_IDLE;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/l2_msg_arb.sv
// msg3-over-msg1 priority arbiter; a saturating starvation counter hands one
// slot to msg1 after three msg3 wins taken while msg1 was waiting.
module l2_msg_arb
    import l2_msg_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic msg1_valid,
    input  logic msg3_valid,
    output logic gnt1,
    output logic gnt3
);

    logic [1:0] fair_cnt;
    logic       msg1_turn;

    always_comb begin
        msg1_turn = (fair_cnt == FAIR_MAX);
        gnt3      = en && msg3_valid && !(msg1_valid && msg1_turn);
        gnt1      = en && msg1_valid && (!msg3_valid || msg1_turn);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fair_cnt <= '0;
        end else if (gnt1) begin
            fair_cnt <= '0;
        end else if (gnt3 && msg1_valid && (fair_cnt != FAIR_MAX)) begin
            fair_cnt <= fair_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/l2_msg_sched.sv
// Current-message scheduler: arbitrates msg1/msg3 into one slot, issues it to
// the cache pipeline, collects invalidation acks and returns the msg2 response.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | slot empty, arbiter may accept msg1 or msg3
//   ST_ISSUE | pipe_req_valid held until pipe_req_ready
//   ST_EXEC  | waiting for the pipe_done pulse
//   ST_ACK   | collecting INV_ACKs for cur_msg_tag until count hits zero
//   ST_RESP  | msg2_valid held until msg2_ready
module l2_msg_sched
    import l2_msg_pkg::*;
#(
    parameter int TAG_W  = 26,
    parameter int SRC_W  = 6,
    parameter int TYPE_W = 8,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              msg1_valid,
    output logic              msg1_ready,
    input  logic [TYPE_W-1:0] msg1_type,
    input  logic [SRC_W-1:0]  msg1_source,
    input  logic [TAG_W-1:0]  msg1_tag,
    input  logic [DATA_W-1:0] msg1_data,

    input  logic              msg3_valid,
    output logic              msg3_ready,
    input  logic [TYPE_W-1:0] msg3_type,
    input  logic [SRC_W-1:0]  msg3_source,
    input  logic [TAG_W-1:0]  msg3_tag,
    input  logic [DATA_W-1:0] msg3_data,

    output logic              pipe_req_valid,
    input  logic              pipe_req_ready,
    output logic [TYPE_W-1:0] pipe_req_type,
    output logic [SRC_W-1:0]  pipe_req_source,
    output logic [TAG_W-1:0]  pipe_req_tag,
    output logic [DATA_W-1:0] pipe_req_data,
    output logic              pipe_req_from_msg3,

    input  logic              pipe_done,
    input  logic [TYPE_W-1:0] pipe_resp_type,
    input  logic              pipe_needs_msg2,
    input  logic [CNT_W-1:0]  pipe_inv_count,

    output logic              msg2_valid,
    input  logic              msg2_ready,
    output logic [TYPE_W-1:0] msg2_type,
    output logic [SRC_W-1:0]  msg2_dest,
    output logic [TAG_W-1:0]  msg2_tag,

    output logic [1:0]        cur_msg_state,
    output logic [TYPE_W-1:0] cur_msg_type,
    output logic [SRC_W-1:0]  cur_msg_source,
    output logic [TAG_W-1:0]  cur_msg_tag,
    output logic              proto_err
);

    sched_state_e      state_q, state_d;
    logic [TYPE_W-1:0] cur_type_q;
    logic [SRC_W-1:0]  cur_src_q;
    logic [TAG_W-1:0]  cur_tag_q;
    logic [DATA_W-1:0] cur_data_q;
    logic              from3_q;
    logic [TYPE_W-1:0] resp_type_q;
    logic              needs_q;
    logic [CNT_W-1:0]  ack_cnt_q;
    logic              proto_err_q;

    logic arb_en, gnt1, gnt3;
    logic ack_match, ack_take, done_ok, proto_viol;

    assign arb_en = (state_q == ST_IDLE) && !rst;

    l2_msg_arb u_arb (
        .clk        (clk),
        .rst        (rst),
        .en         (arb_en),
        .msg1_valid (msg1_valid),
        .msg3_valid (msg3_valid),
        .gnt1       (gnt1),
        .gnt3       (gnt3)
    );

    always_comb begin
        ack_match  = msg3_valid && (msg3_type == TYPE_W'(L2_MSG_INV_ACK))
                     && (msg3_tag == cur_tag_q);
        ack_take   = (state_q == ST_ACK) && !rst && ack_match;
        done_ok    = (state_q == ST_EXEC) && pipe_done;
        // A msg3 message (writeback/ack) must never trigger further invalidations.
        proto_viol = pipe_done && ((state_q != ST_EXEC)
                     || ((pipe_inv_count != '0) && from3_q));
        msg1_ready = gnt1;
        msg3_ready = gnt3 || ack_take;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt1 || gnt3) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (pipe_req_ready) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (pipe_done) begin
                    if (pipe_inv_count != '0)  state_d = ST_ACK;
                    else if (pipe_needs_msg2)  state_d = ST_RESP;
                    else                       state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (ack_take && (ack_cnt_q == CNT_W'(1)))
                    state_d = needs_q ? ST_RESP : ST_IDLE;
            end
            ST_RESP: begin
                if (msg2_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_type_q  <= '0;
            cur_src_q   <= '0;
            cur_tag_q   <= '0;
            cur_data_q  <= '0;
            from3_q     <= 1'b0;
            resp_type_q <= '0;
            needs_q     <= 1'b0;
            ack_cnt_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (gnt3) begin
                cur_type_q <= msg3_type;
                cur_src_q  <= msg3_source;
                cur_tag_q  <= msg3_tag;
                cur_data_q <= msg3_data;
                from3_q    <= 1'b1;
            end else if (gnt1) begin
                cur_type_q <= msg1_type;
                cur_src_q  <= msg1_source;
                cur_tag_q  <= msg1_tag;
                cur_data_q <= msg1_data;
                from3_q    <= 1'b0;
            end
            if (done_ok) begin
                resp_type_q <= pipe_resp_type;
                needs_q     <= pipe_needs_msg2;
                ack_cnt_q   <= pipe_inv_count;
            end else if (ack_take && (ack_cnt_q != '0)) begin
                ack_cnt_q <= ack_cnt_q - CNT_W'(1);
            end
            if (proto_viol) proto_err_q <= 1'b1;
        end
    end

    always_comb begin
        pipe_req_valid     = (state_q == ST_ISSUE);
        pipe_req_type      = cur_type_q;
        pipe_req_source    = cur_src_q;
        pipe_req_tag       = cur_tag_q;
        pipe_req_data      = cur_data_q;
        pipe_req_from_msg3 = from3_q;
        msg2_valid         = (state_q == ST_RESP);
        msg2_type          = resp_type_q;
        msg2_dest          = cur_src_q;
        msg2_tag           = cur_tag_q;
        cur_msg_state      = cur_state_enc(state_q);
        cur_msg_type       = cur_type_q;
        cur_msg_source     = cur_src_q;
        cur_msg_tag        = cur_tag_q;
        proto_err          = proto_err_q;
    end

endmodule

// File: tb/tb_l2_msg_sched.sv
// Self-checking bench for l2_msg_sched: arbitration table, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_l2_msg_sched;
    import l2_msg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        msg1_valid, msg1_ready;
    logic [7:0]  msg1_type;
    logic [5:0]  msg1_source;
    logic [25:0] msg1_tag;
    logic [63:0] msg1_data;
    logic        msg3_valid, msg3_ready;
    logic [7:0]  msg3_type;
    logic [5:0]  msg3_source;
    logic [25:0] msg3_tag;
    logic [63:0] msg3_data;
    logic        pipe_req_valid, pipe_req_ready;
    logic [7:0]  pipe_req_type;
    logic [5:0]  pipe_req_source;
    logic [25:0] pipe_req_tag;
    logic [63:0] pipe_req_data;
    logic        pipe_req_from_msg3;
    logic        pipe_done;
    logic [7:0]  pipe_resp_type;
    logic        pipe_needs_msg2;
    logic [6:0]  pipe_inv_count;
    logic        msg2_valid, msg2_ready;
    logic [7:0]  msg2_type;
    logic [5:0]  msg2_dest;
    logic [25:0] msg2_tag;
    logic [1:0]  cur_msg_state;
    logic [7:0]  cur_msg_type;
    logic [5:0]  cur_msg_source;
    logic [25:0] cur_msg_tag;
    logic        proto_err;

    l2_msg_sched dut (
        .clk(clk), .rst(rst),
        .msg1_valid(msg1_valid), .msg1_ready(msg1_ready), .msg1_type(msg1_type),
        .msg1_source(msg1_source), .msg1_tag(msg1_tag), .msg1_data(msg1_data),
        .msg3_valid(msg3_valid), .msg3_ready(msg3_ready), .msg3_type(msg3_type),
        .msg3_source(msg3_source), .msg3_tag(msg3_tag), .msg3_data(msg3_data),
        .pipe_req_valid(pipe_req_valid), .pipe_req_ready(pipe_req_ready),
        .pipe_req_type(pipe_req_type), .pipe_req_source(pipe_req_source),
        .pipe_req_tag(pipe_req_tag), .pipe_req_data(pipe_req_data),
        .pipe_req_from_msg3(pipe_req_from_msg3),
        .pipe_done(pipe_done), .pipe_resp_type(pipe_resp_type),
        .pipe_needs_msg2(pipe_needs_msg2), .pipe_inv_count(pipe_inv_count),
        .msg2_valid(msg2_valid), .msg2_ready(msg2_ready), .msg2_type(msg2_type),
        .msg2_dest(msg2_dest), .msg2_tag(msg2_tag),
        .cur_msg_state(cur_msg_state), .cur_msg_type(cur_msg_type),
        .cur_msg_source(cur_msg_source), .cur_msg_tag(cur_msg_tag),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v1;
        logic v3;
        logic exp_r1;
        logic exp_r3;
    } arb_vec_t;

    typedef struct {
        logic [7:0]  typ;
        logic [5:0]  src;
        logic [25:0] tag;
        logic [63:0] data;
        logic        from3;
    } msg_t;

    typedef struct {
        logic [7:0]  typ;
        logic [5:0]  dest;
        logic [25:0] tag;
    } rsp_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        msg1_valid = 0; msg1_type = 0; msg1_source = 0; msg1_tag = 0; msg1_data = 0;
        msg3_valid = 0; msg3_type = 0; msg3_source = 0; msg3_tag = 0; msg3_data = 0;
        pipe_req_ready = 0; pipe_done = 0; pipe_resp_type = 0;
        pipe_needs_msg2 = 0; pipe_inv_count = 0; msg2_ready = 0;
    endtask

    task automatic do_reset();
        step();
        rst = 1;
        clear_inputs();
        step();
        step();
        rst = 0;
    endtask

    // Accept one message on the chosen channel, issue it, and pulse pipe_done.
    // Returns in the cycle after EXEC.
    task automatic issue_and_done(input logic from3, input logic [7:0] typ,
                                  input logic [5:0] src, input logic [25:0] tag,
                                  input logic needs, input logic [7:0] rtype,
                                  input logic [6:0] cnt);
        logic got;
        got = 0;
        step();
        if (from3) begin
            msg3_valid = 1; msg3_type = typ; msg3_source = src; msg3_tag = tag;
            msg3_data = 64'h3333_0000_0000_0000 | 64'(tag);
        end else begin
            msg1_valid = 1; msg1_type = typ; msg1_source = src; msg1_tag = tag;
            msg1_data = 64'h1111_0000_0000_0000 | 64'(tag);
        end
        pipe_req_ready = 1;
        for (int i = 0; i < 8 && !got; i++) begin
            if (i > 0) step();
            #1;
            got = from3 ? msg3_ready : msg1_ready;
        end
        if (!got) chk("accept_timeout", 0, 1);
        step();
        msg1_valid = 0; msg3_valid = 0;
        #1;
        chk("issue_valid", pipe_req_valid, 1);
        step();
        pipe_req_ready = 0;
        pipe_done = 1; pipe_resp_type = rtype; pipe_needs_msg2 = needs; pipe_inv_count = cnt;
        #1;
        step();
        pipe_done = 0; pipe_needs_msg2 = 0; pipe_inv_count = 0;
        #1;
    endtask

    // Runs a just-granted message through to IDLE with no response.
    task automatic complete_simple();
        step();
        msg1_valid = 0; msg3_valid = 0; pipe_req_ready = 1;
        #1;
        step();
        pipe_req_ready = 0; pipe_done = 1; pipe_needs_msg2 = 0; pipe_inv_count = 0;
        #1;
        step();
        pipe_done = 0;
        #1;
    endtask

    task automatic run_random();
        msg_t q1[$];
        msg_t q3[$];
        msg_t acc_q[$];
        rsp_t exp_q[$];
        msg_t m;
        msg_t inflight;
        rsp_t r;
        int   fair, n_gen, n_acc, done_wait;
        logic fly_needs, want3, got3;
        logic [7:0] fly_rtype;
        fair = 0; n_gen = 0; n_acc = 0; done_wait = 0;
        fly_needs = 0; fly_rtype = 0;
        inflight = '{default: '0};
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            if (cyc < 2000 && n_gen < 150 && $urandom_range(0, 2) == 0) begin
                m.typ   = 8'($urandom_range(1, 8'h11));
                m.src   = 6'($urandom);
                m.tag   = 26'($urandom);
                m.data  = {$urandom, $urandom};
                m.from3 = 1'($urandom_range(0, 1));
                if (m.from3) q3.push_back(m);
                else         q1.push_back(m);
                n_gen++;
            end
            msg1_valid = (q1.size() > 0);
            if (q1.size() > 0) begin
                msg1_type = q1[0].typ; msg1_source = q1[0].src;
                msg1_tag = q1[0].tag; msg1_data = q1[0].data;
            end
            msg3_valid = (q3.size() > 0);
            if (q3.size() > 0) begin
                msg3_type = q3[0].typ; msg3_source = q3[0].src;
                msg3_tag = q3[0].tag; msg3_data = q3[0].data;
            end
            pipe_req_ready = 1'($urandom_range(0, 1));
            msg2_ready     = 1'($urandom_range(0, 1));
            pipe_done      = 0;
            pipe_inv_count = 0;
            if (done_wait > 0) begin
                done_wait--;
                if (done_wait == 0) begin
                    pipe_done = 1; pipe_needs_msg2 = fly_needs; pipe_resp_type = fly_rtype;
                    if (fly_needs) exp_q.push_back('{fly_rtype, inflight.src, inflight.tag});
                end
            end
            #1;
            chk("rand_ready_exclusive", msg1_ready & msg3_ready, 0);
            if ((msg1_valid && msg1_ready) || (msg3_valid && msg3_ready)) begin
                want3 = (msg1_valid && msg3_valid) ? (fair != 3) : msg3_valid;
                got3  = msg3_valid && msg3_ready;
                chk("rand_grant_msg3", got3, want3);
                if (got3) begin
                    m = q3.pop_front();
                    if (msg1_valid && fair < 3) fair++;
                end else begin
                    m = q1.pop_front();
                    fair = 0;
                end
                acc_q.push_back(m);
                n_acc++;
            end
            if (pipe_req_valid && pipe_req_ready) begin
                if (acc_q.size() == 0) begin
                    chk("rand_req_unexpected", 1, 0);
                end else begin
                    inflight = acc_q.pop_front();
                    chk("rand_req_type", pipe_req_type, inflight.typ);
                    chk("rand_req_source", pipe_req_source, inflight.src);
                    chk("rand_req_tag", pipe_req_tag, inflight.tag);
                    chk("rand_req_data", pipe_req_data, inflight.data);
                    chk("rand_req_from3", pipe_req_from_msg3, inflight.from3);
                end
                done_wait = $urandom_range(1, 3);
                fly_needs = 1'($urandom_range(0, 1));
                fly_rtype = 8'($urandom);
            end
            if (msg2_valid && msg2_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand_msg2_unexpected", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    chk("rand_msg2_type", msg2_type, r.typ);
                    chk("rand_msg2_dest", msg2_dest, r.dest);
                    chk("rand_msg2_tag", msg2_tag, r.tag);
                end
            end
            if (cyc >= 2000 && n_acc == n_gen && acc_q.size() == 0 && done_wait == 0
                && exp_q.size() == 0 && cur_msg_state == 2'd0) break;
        end
        msg1_valid = 0; msg3_valid = 0; msg2_ready = 0; pipe_req_ready = 0; pipe_done = 0;
        chk("rand_all_accepted", n_acc, n_gen);
        chk("rand_issue_drained", acc_q.size(), 0);
        chk("rand_resp_drained", exp_q.size(), 0);
        chk("rand_no_proto_err", proto_err, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

    arb_vec_t arb_tab[14];

    initial begin
        // v1, v3 -> expected msg1_ready, msg3_ready (fairness count in comment)
        arb_tab[0]  = '{0, 0, 0, 0};
        arb_tab[1]  = '{1, 0, 1, 0};   // 0
        arb_tab[2]  = '{0, 1, 0, 1};   // 0, msg1 not waiting
        arb_tab[3]  = '{1, 1, 0, 1};   // 1
        arb_tab[4]  = '{1, 1, 0, 1};   // 2
        arb_tab[5]  = '{0, 1, 0, 1};   // 2
        arb_tab[6]  = '{1, 1, 0, 1};   // 3
        arb_tab[7]  = '{1, 1, 1, 0};   // 0
        arb_tab[8]  = '{1, 1, 0, 1};   // 1
        arb_tab[9]  = '{1, 0, 1, 0};   // 0
        arb_tab[10] = '{1, 1, 0, 1};   // 1
        arb_tab[11] = '{1, 1, 0, 1};   // 2
        arb_tab[12] = '{1, 1, 0, 1};   // 3
        arb_tab[13] = '{1, 1, 1, 0};   // 0

        rst = 1;
        clear_inputs();
        step(); step(); step();
        #1;
        chk("rst_state", cur_msg_state, 0);
        chk("rst_pipe_req_valid", pipe_req_valid, 0);
        chk("rst_msg2_valid", msg2_valid, 0);
        chk("rst_msg1_ready", msg1_ready, 0);
        chk("rst_msg3_ready", msg3_ready, 0);
        chk("rst_cur_tag", cur_msg_tag, 0);
        chk("rst_pipe_req_data", pipe_req_data, 0);
        chk("rst_proto_err", proto_err, 0);
        step();
        rst = 0;

        for (int i = 0; i < 14; i++) begin
            step();
            msg1_valid = arb_tab[i].v1; msg1_type = L2_MSG_GET_S; msg1_tag = 26'(i);
            msg3_valid = arb_tab[i].v3; msg3_type = L2_MSG_PUT_M; msg3_tag = 26'(100 + i);
            #1;
            chk($sformatf("arb%0d_msg1_ready", i), msg1_ready, arb_tab[i].exp_r1);
            chk($sformatf("arb%0d_msg3_ready", i), msg3_ready, arb_tab[i].exp_r3);
            if (msg1_ready || msg3_ready) complete_simple();
            else begin
                msg1_valid = 0; msg3_valid = 0;
            end
        end

        // Minimum-turnaround transaction
        step();
        msg1_valid = 1; msg1_type = 8'h01; msg1_source = 6'd3; msg1_tag = 26'h5;
        msg1_data = 64'hDEAD_BEEF_0000_0001;
        pipe_req_ready = 1; msg2_ready = 1;
        #1;
        chk("t1_accept_n", msg1_ready, 1);
        step();
        msg1_valid = 0;
        #1;
        chk("t1_req_valid_n1", pipe_req_valid, 1);
        chk("t1_state_n1", cur_msg_state, 1);
        chk("t1_req_tag", pipe_req_tag, 26'h5);
        chk("t1_req_source", pipe_req_source, 3);
        chk("t1_req_data", pipe_req_data, 64'hDEAD_BEEF_0000_0001);
        chk("t1_req_from3", pipe_req_from_msg3, 0);
        step();
        pipe_done = 1; pipe_resp_type = L2_MSG_DATA_S; pipe_needs_msg2 = 1; pipe_inv_count = 0;
        #1;
        chk("t1_req_valid_n2", pipe_req_valid, 0);
        chk("t1_state_n2", cur_msg_state, 1);
        step();
        pipe_done = 0; pipe_needs_msg2 = 0;
        #1;
        chk("t1_msg2_valid_n3", msg2_valid, 1);
        chk("t1_msg2_dest", msg2_dest, 3);
        chk("t1_msg2_tag", msg2_tag, 26'h5);
        chk("t1_msg2_type", msg2_type, L2_MSG_DATA_S);
        chk("t1_state_n3", cur_msg_state, 3);
        step();
        msg1_valid = 1; msg1_type = L2_MSG_GET_M; msg1_source = 6'd7; msg1_tag = 26'h2A;
        msg2_ready = 0;
        #1;
        chk("t1_state_n4", cur_msg_state, 0);
        chk("t1_msg2_valid_n4", msg2_valid, 0);
        chk("t1_accept_n4", msg1_ready, 1);

        // Response held under msg2_ready low for five cycles
        step();
        msg1_valid = 0;
        step();
        pipe_done = 1; pipe_resp_type = L2_MSG_DATA_M; pipe_needs_msg2 = 1;
        step();
        pipe_done = 0; pipe_needs_msg2 = 0; pipe_req_ready = 0;
        msg1_valid = 1; msg3_valid = 1; msg3_type = L2_MSG_PUT_M;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            #1;
            chk($sformatf("stall%0d_msg2_valid", i), msg2_valid, 1);
            chk($sformatf("stall%0d_msg2_type", i), msg2_type, L2_MSG_DATA_M);
            chk($sformatf("stall%0d_msg2_dest", i), msg2_dest, 7);
            chk($sformatf("stall%0d_msg2_tag", i), msg2_tag, 26'h2A);
            chk($sformatf("stall%0d_no_accept", i), {msg1_ready, msg3_ready}, 0);
        end
        step();
        msg2_ready = 1; msg1_valid = 0; msg3_valid = 0;
        #1;
        chk("stall_release_valid", msg2_valid, 1);
        step();
        msg2_ready = 0;
        #1;
        chk("stall_idle", cur_msg_state, 0);

        // Ack collection with a non-matching ack in front
        issue_and_done(0, L2_MSG_GET_M, 6'd9, 26'h77, 1, L2_MSG_DATA_E, 7'd3);
        chk("ack_enter", cur_msg_state, 2);
        msg3_valid = 1; msg3_type = L2_MSG_INV_ACK; msg3_tag = 26'h78; msg1_valid = 1;
        #1;
        chk("ack_badtag_stall", msg3_ready, 0);
        chk("ack_msg1_stall", msg1_ready, 0);
        step();
        #1;
        chk("ack_badtag_state", cur_msg_state, 2);
        msg1_valid = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            msg3_valid = 1; msg3_type = L2_MSG_INV_ACK; msg3_tag = 26'h77;
            #1;
            chk($sformatf("ack%0d_ready", k), msg3_ready, 1);
            step();
            msg3_valid = 0;
            #1;
            chk($sformatf("ack%0d_state", k), cur_msg_state, (k == 2) ? 3 : 2);
        end
        chk("ack_msg2_tag", msg2_tag, 26'h77);
        chk("ack_msg2_dest", msg2_dest, 9);
        chk("ack_no_err", proto_err, 0);
        msg2_ready = 1;
        step();
        msg2_ready = 0;
        #1;
        chk("ack_done_idle", cur_msg_state, 0);

        // Reset while waiting on two acks
        issue_and_done(0, L2_MSG_UPGRADE, 6'd12, 26'h1234, 1, L2_MSG_DATA_M, 7'd2);
        chk("rack_enter", cur_msg_state, 2);
        rst = 1;
        step();
        #1;
        chk("rack_state", cur_msg_state, 0);
        chk("rack_req_valid", pipe_req_valid, 0);
        chk("rack_msg2_valid", msg2_valid, 0);
        chk("rack_cur_type", cur_msg_type, 0);
        chk("rack_cur_source", cur_msg_source, 0);
        chk("rack_cur_tag", cur_msg_tag, 0);
        chk("rack_msg2_type", msg2_type, 0);
        chk("rack_readys", {msg1_ready, msg3_ready}, 0);
        chk("rack_proto_err", proto_err, 0);
        rst = 0;

        do_reset();
        run_random();

        // pipe_done while idle
        step();
        pipe_done = 1;
        step();
        pipe_done = 0;
        #1;
        chk("idle_done_err", proto_err, 1);
        chk("idle_done_state", cur_msg_state, 0);
        repeat (3) step();
        #1;
        chk("idle_done_sticky", proto_err, 1);

        // Invalidations requested for a msg3 message
        do_reset();
        #1;
        chk("m3err_cleared", proto_err, 0);
        issue_and_done(1, L2_MSG_PUT_M, 6'd5, 26'h99, 0, 8'h00, 7'd1);
        chk("m3err_set", proto_err, 1);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_msg_sched.md
# l2_msg_sched

Message scheduler sitting in front of the L2 cache pipeline at the ILA message level. It arbitrates the two inbound channels, msg1 (core requests) and msg3 (writebacks/acks), into the single current-message slot. It sequences that message through the pipeline, collects invalidation acks, and drives the msg2 response channel. Its `cur_msg_*` outputs are the architectural current-message state used by the L2 refinement checks.

## Interface
Parameters:
- TAG_W, 26, message tag width
- SRC_W, 6, source/destination id width
- TYPE_W, 8, message type width
- DATA_W, 64, message payload width
- CNT_W, 7, invalidation-ack counter width

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- msg1_valid / msg1_ready  in / out  1  request channel handshake
- msg1_type, msg1_source, msg1_tag, msg1_data  in  TYPE_W/SRC_W/TAG_W/DATA_W  request fields
- msg3_valid / msg3_ready  in / out  1  writeback/ack channel handshake
- msg3_type, msg3_source, msg3_tag, msg3_data  in  TYPE_W/SRC_W/TAG_W/DATA_W  msg3 fields
- pipe_req_valid / pipe_req_ready  out / in  1  issue to cache pipeline
- pipe_req_type, pipe_req_source, pipe_req_tag, pipe_req_data  out  TYPE_W/SRC_W/TAG_W/DATA_W  issued message
- pipe_req_from_msg3  out  1  issued message came from msg3
- pipe_done  in  1  single-cycle completion pulse from pipeline
- pipe_resp_type  in  TYPE_W  msg2 type to send; sampled on pipe_done
- pipe_needs_msg2  in  1  response required; sampled on pipe_done
- pipe_inv_count  in  CNT_W  acks to collect; sampled on pipe_done
- msg2_valid / msg2_ready  out / in  1  response channel handshake
- msg2_type, msg2_dest, msg2_tag  out  TYPE_W/SRC_W/TAG_W  response fields
- cur_msg_state  out  2  0 idle, 1 issue/exec, 2 ack-wait, 3 respond
- cur_msg_type, cur_msg_source, cur_msg_tag  out  TYPE_W/SRC_W/TAG_W  current message
- proto_err  out  1  sticky protocol-violation flag

## Operation
- **FSM states:** IDLE, ISSUE, EXEC, ACK, RESP.
  - `cur_msg_state` mapping: IDLE→0; ISSUE and EXEC→1; ACK→2; RESP→3.
- **IDLE, arbitration:**
  - msg3 has priority over msg1.
  - Fairness counter: 2 bits, saturating. It increments on each msg3 grant taken while msg1_valid is high. When it is 3 and both channels are valid, msg1 is granted, and the counter clears on any msg1 grant.
  - `msg1_ready` / `msg3_ready` are combinational from state, both valids and the counter. At most one is high.
- **Accept:** on a handshake, latch type/source/tag/data and the from-msg3 bit, then go to ISSUE.
- **ISSUE:** `pipe_req_valid`=1 with the latched fields held stable. On `pipe_req_ready`, go to EXEC.
- **EXEC:** wait for `pipe_done`, then latch resp_type, needs_msg2 and the ack count. Next state:
  - ack count > 0 → ACK
  - ack count = 0 and needs_msg2 → RESP
  - otherwise → IDLE
- **ACK:**
  - `msg3_ready` is high only for msg3 with type == L2_MSG_INV_ACK and tag == `cur_msg_tag`. Each such accept decrements the count.
  - The accept that brings the count to 0 moves to RESP if needs_msg2, else IDLE.
  - Non-matching msg3 and all msg1 stall.
- **RESP:**
  - `msg2_valid`=1 with `msg2_type`=latched resp_type, `msg2_dest`=`cur_msg_source`, `msg2_tag`=`cur_msg_tag`, all held stable.
  - On `msg2_ready`, go to IDLE.
- **proto_err** is set (sticky until rst) on any of:
  - `pipe_done` outside EXEC (otherwise ignored)
  - `pipe_done` in EXEC with `pipe_inv_count` > 0 and msg from msg3

## Timing
- **Reset values:** state IDLE; all valid/ready outputs 0, except the readys, which follow IDLE arbitration once rst is low; all `cur_*`/`msg2_*`/`pipe_req_*` fields 0; counters 0; `proto_err` 0.
- **Reset mid-operation:** rst in any state returns to IDLE next cycle and drops any held valid.
- **Latency:** accept at cycle N → `pipe_req_valid` at N+1.
- **Minimum turnaround** (ready, done and msg2_ready all immediate): req handshake N+1, EXEC N+2 with done, `msg2_valid` N+3, IDLE N+4, next accept N+4.
- **No bypass:** `pipe_done` in the same cycle as the req handshake is not possible (EXEC is entered after it).
- **Valid stability:** `pipe_req_valid` and `msg2_valid` never drop without their ready. `msg2_ready` without valid is ignored.
- **Ack counter** is CNT_W wide with no wrap: it is loaded only from `pipe_inv_count` and decrements only while nonzero.

## Structure
- Package `l2_msg_pkg`: TYPE_W-wide message type constants (L2_MSG_INV_ACK = 8'h12 plus the request/response set), state enum, `cur_msg_state` encodings.
- Sub-module `l2_msg_arb`: the msg1/msg3 priority arbiter with fairness counter. Inputs: both valids, enable (state==IDLE). Outputs: both grants.

## Test plan
- msg1 only, type 8'h01, tag 26'h5, source 6'd3; pipe_done with needs_msg2=1, count 0 → `pipe_req` at N+1, `msg2_valid` at N+3 with dest 3, tag 5, IDLE at N+4.
- msg1 and msg3 both continuously valid → grant order msg3,msg3,msg3,msg1 repeating; counter clears after msg1.
- pipe_done count 3 → ACK. Inject a non-matching tag ack (stalled, ready=0), then 3 matching acks → RESP after the third; `cur_msg_state` goes 2 then 3.
- msg2_ready held low 5 cycles → `msg2_valid` and fields stable; no msg1/msg3 accepted.
- rst asserted in ACK with count 2 → next cycle IDLE, all outputs at reset values, `proto_err` 0.
- pipe_done in IDLE → `proto_err`=1 and stays 1; state unchanged.
